// File: rtl/mult_manager.sv
// Pipelined RV32M multiply unit: MUL/MULH/MULHSU/MULHU carried through STAGES
// registered stages to a ready/valid register-file writeback port.
module mult_manager #(
  parameter int unsigned STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_valid_i,
  output logic        mult_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic [4:0]  rd_addrs_o [STAGES],
  output logic [STAGES-1:0] uses_o,
  output logic        busy_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  logic [STAGES-1:0] use_q;
  logic [4:0]        rd_q   [STAGES];
  logic [31:0]       data_q [STAGES];

  logic        adv;
  logic        live;
  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic [63:0] prod;
  logic [31:0] res;

  assign adv          = !(use_q[STAGES-1] && !wb_ready_i);
  assign mult_ready_o = adv;

  // rd=0 and divide-class funct3 still handshake but enter the pipe as bubbles.
  assign live = mult_valid_i && !funct3_i[2] && (rd_addr_i != 5'd0);

  always_comb begin
    a_ext = {(funct3_i[1:0] != 2'b11) & rs1_data_i[31], rs1_data_i};
    b_ext = {(funct3_i[1:0] == 2'b00 || funct3_i[1:0] == 2'b01) & rs2_data_i[31], rs2_data_i};
    // Low 64 bits of the 33x33 signed product equal the 64x64 product of the
    // sign-extended operands taken modulo 2^64.
    prod  = {{31{a_ext[32]}}, a_ext} * {{31{b_ext[32]}}, b_ext};
    res   = (funct3_i[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      use_q     <= '0;
      rd_q[0]   <= '0;
      data_q[0] <= '0;
    end else if (adv) begin
      use_q     <= {use_q[STAGES-2:0], live};
      rd_q[0]   <= live ? rd_addr_i : '0;
      data_q[0] <= live ? res : '0;
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q[g]   <= '0;
        data_q[g] <= '0;
      end else if (adv) begin
        rd_q[g]   <= rd_q[g-1];
        data_q[g] <= data_q[g-1];
      end
    end
  end

  assign rd_addrs_o = rd_q;
  assign uses_o     = use_q;
  assign busy_o     = |use_q;
  assign wb_valid_o = use_q[STAGES-1];
  assign wb_rd_o    = rd_q[STAGES-1];
  assign wb_data_o  = data_q[STAGES-1];

endmodule
